// File: rtl/flash_spi_reader.sv
// SPI flash read engine: fetches one 32-bit little-endian word per CPU request with a READ (0x03) command.
// Optional single-entry word cache enabled by defining FLASH_SPI_READER_CACHE_EN.
module flash_spi_reader #(
    parameter logic [23:0] FLASH_BASE = 24'h100000,
    parameter logic [7:0]  READ_CMD   = 8'h03
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flash_read_en,
    input  logic [21:0] cpu_address,
    output logic        flash_read_ready,
    output logic [31:0] flash_read_data,
    output logic        flash_sck,
    output logic        flash_cs_n,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [5:0]  bit_cnt_q;
    logic        phase_q;
    logic [31:0] tx_q;
    logic [31:0] rx_q;
    logic        ready_q;
    logic [31:0] data_q;
    logic        sck_q;
    logic        cs_n_q;
    logic        mosi_q;

    logic [23:0] byte_addr_d;
    logic [31:0] rx_word_d;
    logic        cache_hit_s;

    // Flash bytes arrive b0 first, so the assembled shift word is reversed byte-wise.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Issued flash byte address and the receive word including the bit being sampled now.
    always_comb begin
        byte_addr_d = {cpu_address, 2'b00} + FLASH_BASE;
        rx_word_d   = {rx_q[30:0], flash_miso};
    end

`ifdef FLASH_SPI_READER_CACHE_EN
    logic        cache_valid_q;
    logic [21:0] cache_tag_q;

    // Hit when the held word belongs to the requested address.
    always_comb begin
        if (cache_valid_q && (cpu_address == cache_tag_q)) begin
            cache_hit_s = 1'b1;
        end else begin
            cache_hit_s = 1'b0;
        end
    end
`else
    assign cache_hit_s = 1'b0;
`endif

    // Transaction FSM with registered SPI pins and CPU handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= 6'd0;
            phase_q   <= 1'b0;
            tx_q      <= 32'd0;
            rx_q      <= 32'd0;
            ready_q   <= 1'b0;
            data_q    <= 32'd0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
`ifdef FLASH_SPI_READER_CACHE_EN
            cache_valid_q <= 1'b0;
            cache_tag_q   <= 22'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    sck_q  <= 1'b0;
                    cs_n_q <= 1'b1;
                    if (flash_read_en && cache_hit_s) begin
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else if (flash_read_en) begin
                        tx_q      <= {READ_CMD, byte_addr_d};
                        cs_n_q    <= 1'b0;
                        mosi_q    <= READ_CMD[7];
                        bit_cnt_q <= 6'd0;
                        phase_q   <= 1'b0;
                        state_q   <= SHIFT;
`ifdef FLASH_SPI_READER_CACHE_EN
                        cache_valid_q <= 1'b0;
                        cache_tag_q   <= cpu_address;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    if (!phase_q) begin
                        sck_q   <= 1'b1;
                        phase_q <= 1'b1;
                    end else begin
                        // Falling SCK: capture MISO and present the next command/address bit.
                        sck_q   <= 1'b0;
                        phase_q <= 1'b0;
                        rx_q    <= rx_word_d;
                        tx_q    <= {tx_q[30:0], 1'b0};
                        if (bit_cnt_q == 6'd63) begin
                            cs_n_q    <= 1'b1;
                            mosi_q    <= 1'b0;
                            data_q    <= byte_swap(rx_word_d);
                            ready_q   <= 1'b1;
                            bit_cnt_q <= 6'd0;
                            state_q   <= DONE;
`ifdef FLASH_SPI_READER_CACHE_EN
                            cache_valid_q <= 1'b1;
`endif
                        end else begin
                            mosi_q    <= tx_q[30];
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    sck_q   <= 1'b0;
                    cs_n_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign flash_read_ready = ready_q;
    assign flash_read_data  = data_q;
    assign flash_sck        = sck_q;
    assign flash_cs_n       = cs_n_q;
    assign flash_mosi       = mosi_q;

endmodule

// File: tb/tb_flash_spi_reader.sv
// Directed bench for flash_spi_reader: vector table of reads against a behavioural SPI flash,
// plus hand-written reset, held-enable, early-drop and (when enabled) cache sequences.
module tb_flash_spi_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        flash_read_en;
    logic [21:0] cpu_address;
    logic        flash_read_ready;
    logic [31:0] flash_read_data;
    logic        flash_sck;
    logic        flash_cs_n;
    logic        flash_mosi;
    logic        flash_miso = 1'b0;

    int total = 0;
    int bad   = 0;

    // Behavioural flash state: bytes to return as {b0,b1,b2,b3}, captured command/address stream.
    int          fbit = 0;
    int          cs_falls = 0;
    logic [31:0] rx_mosi = 32'd0;
    logic [31:0] flash_bytes = 32'd0;

    typedef struct {
        logic [21:0] addr;
        logic [31:0] bytes;
        logic [31:0] exp_mosi;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    flash_spi_reader dut (
        .clk              (clk),
        .reset            (reset),
        .flash_read_en    (flash_read_en),
        .cpu_address      (cpu_address),
        .flash_read_ready (flash_read_ready),
        .flash_read_data  (flash_read_data),
        .flash_sck        (flash_sck),
        .flash_cs_n       (flash_cs_n),
        .flash_mosi       (flash_mosi),
        .flash_miso       (flash_miso)
    );

    always #5 clk = ~clk;

    // Flash model: capture MOSI on SCK rise for 32 bits, then present data bits MSB-first.
    always @(posedge flash_sck or negedge flash_cs_n) begin
        if (flash_sck) begin
            if (fbit < 32) rx_mosi = {rx_mosi[30:0], flash_mosi};
            else if (fbit < 64) flash_miso = flash_bytes[63 - fbit];
            fbit = fbit + 1;
        end else begin
            fbit = 0;
            rx_mosi = 32'd0;
            flash_miso = 1'b0;
            cs_falls = cs_falls + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Counts edges after the one that sampled the request until ready is seen.
    task automatic wait_ready(output int lat);
        lat = 0;
        @(posedge clk);
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (flash_read_ready || lat >= 300) break;
        end
    endtask

    task automatic do_read(input string nm, input logic [21:0] a, input logic [31:0] b,
                           input logic [31:0] em, input logic [31:0] ed);
        int lat;
        @(negedge clk);
        flash_read_en = 1'b1;
        cpu_address   = a;
        flash_bytes   = b;
        wait_ready(lat);
        chk({nm, " latency"}, 32'(lat), 32'd128);
        chk({nm, " data"}, flash_read_data, ed);
        chk({nm, " mosi"}, rx_mosi, em);
        chk({nm, " sck count"}, 32'(fbit), 32'd64);
        chk({nm, " cs_n at ready"}, {31'd0, flash_cs_n}, 32'd1);
        flash_read_en = 1'b0;
        @(posedge clk); #1;
        chk({nm, " ready width"}, {31'd0, flash_read_ready}, 32'd0);
    endtask

    initial begin
        int cnt;
        int falls0;
        int extra;

        vecs[0] = '{22'h000010, 32'h11223344, 32'h03100040, 32'h44332211};
        vecs[1] = '{22'h3FFFFF, 32'hA1B2C3D4, 32'h030FFFFC, 32'hD4C3B2A1};
        vecs[2] = '{22'h000000, 32'hDEADBEEF, 32'h03100000, 32'hEFBEADDE};
        vecs[3] = '{22'h2AAAAA, 32'h00FF0180, 32'h03BAAAA8, 32'h8001FF00};

        reset = 1'b1;
        flash_read_en = 1'b0;
        cpu_address = 22'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst ready", {31'd0, flash_read_ready}, 32'd0);
        chk("rst data", flash_read_data, 32'd0);
        chk("rst sck", {31'd0, flash_sck}, 32'd0);
        chk("rst cs_n", {31'd0, flash_cs_n}, 32'd1);
        chk("rst mosi", {31'd0, flash_mosi}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].bytes, vecs[i].exp_mosi, vecs[i].exp_data);
        end

        // Enable held through ready/DONE: next transfer starts only at the following IDLE edge.
        @(negedge clk);
        flash_read_en = 1'b1;
        cpu_address   = 22'h000123;
        flash_bytes   = 32'h01020304;
        wait_ready(cnt);
        chk("hold first latency", 32'(cnt), 32'd128);
        chk("hold first data", flash_read_data, 32'h04030201);
        cpu_address = 22'h000124;
        flash_bytes = 32'h55667788;
        @(posedge clk); #1;
        chk("hold done ready", {31'd0, flash_read_ready}, 32'd0);
        chk("hold done cs_n", {31'd0, flash_cs_n}, 32'd1);
        @(posedge clk); #1;
        chk("hold restart cs_n", {31'd0, flash_cs_n}, 32'd0);
        cnt = 0;
        while (1) begin
            @(posedge clk); #1;
            cnt++;
            if (flash_read_ready || cnt >= 300) break;
        end
        flash_read_en = 1'b0;
        chk("hold second latency", 32'(cnt), 32'd128);
        chk("hold second data", flash_read_data, 32'h88776655);
        chk("hold second mosi", rx_mosi, 32'h03100490);
        @(posedge clk); #1;

        // Enable dropped during bit 40: transfer still completes once, no restart.
        @(negedge clk);
        flash_read_en = 1'b1;
        cpu_address   = 22'h000200;
        flash_bytes   = 32'h9ABCDEF0;
        repeat (81) @(posedge clk);
        @(negedge clk);
        flash_read_en = 1'b0;
        cnt = 80;
        while (1) begin
            @(posedge clk); #1;
            cnt++;
            if (flash_read_ready || cnt >= 300) break;
        end
        chk("drop latency", 32'(cnt), 32'd128);
        chk("drop data", flash_read_data, 32'hF0DEBC9A);
        chk("drop mosi", rx_mosi, 32'h03100800);
        falls0 = cs_falls;
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (flash_read_ready || !flash_cs_n) extra++;
        end
        chk("drop no restart", 32'(extra + cs_falls - falls0), 32'd0);

        // Reset held 3 cycles during bit 20 aborts the transfer.
        @(negedge clk);
        flash_read_en = 1'b1;
        cpu_address   = 22'h000010;
        flash_bytes   = 32'h11223344;
        repeat (42) @(posedge clk);
        @(negedge clk);
        chk("abort mid cs_n", {31'd0, flash_cs_n}, 32'd0);
        reset = 1'b1;
        flash_read_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort cs_n", {31'd0, flash_cs_n}, 32'd1);
        chk("abort sck", {31'd0, flash_sck}, 32'd0);
        chk("abort ready", {31'd0, flash_read_ready}, 32'd0);
        chk("abort mosi", {31'd0, flash_mosi}, 32'd0);
        do_read("after abort", vecs[0].addr, vecs[0].bytes, vecs[0].exp_mosi, vecs[0].exp_data);

`ifdef FLASH_SPI_READER_CACHE_EN
        do_read("cache fill11", 22'h000011, 32'h11223344, 32'h03100044, 32'h44332211);
        do_read("cache fill10", 22'h000010, 32'h11223344, 32'h03100040, 32'h44332211);
        falls0 = cs_falls;
        @(negedge clk);
        flash_read_en = 1'b1;
        cpu_address   = 22'h000010;
        flash_bytes   = 32'h00000000;
        @(posedge clk); #1;
        chk("cache hit ready", {31'd0, flash_read_ready}, 32'd1);
        chk("cache hit data", flash_read_data, 32'h44332211);
        flash_read_en = 1'b0;
        @(posedge clk); #1;
        chk("cache hit width", {31'd0, flash_read_ready}, 32'd0);
        chk("cache hit no cs", 32'(cs_falls - falls0), 32'd0);
        do_read("cache miss11", 22'h000011, 32'hCAFEF00D, 32'h03100044, 32'h0DF0FECA);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
